// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative write-back data cache:
// FSM state encoding, RISC-V funct3 size codes, address-slice width helpers,
// and load/store lane formatting helpers.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Word-offset field width.
    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Set-index field width.
    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    // Tag field width: what remains above index, offset and byte bits.
    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                          input int unsigned line_words);
        return addr_w - $clog2(sets) - $clog2(line_words) - 2;
    endfunction

    // Way-number width; a direct-mapped cache still carries one bit.
    function automatic int unsigned way_w(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Extract and sign/zero-extend load data; unknown sizes return zero.
    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] bsel,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{bsel, 3'b000} +: 8];
        h = word[{bsel[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Byte enables for a store; unknown sizes enable nothing.
    function automatic logic [3:0] store_be(input logic [1:0] bsel, input logic [2:0] f3);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << bsel;
            F3_H:    be = bsel[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data across the byte lanes it may land in.
    function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [2:0] f3);
        logic [31:0] l;
        case (f3)
            F3_B:    l = {4{wdata[7:0]}};
            F3_H:    l = {2{wdata[15:0]}};
            default: l = wdata;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set replacement state for the data cache.
// Ports: clk, rst (sync, active-high), index (set addressed this cycle),
// hit_way/update (touch on a hit), fill_way/fill (touch on a line fill),
// victim_way (least-recently-used way of the addressed set).
// WAYS=1 has no state, WAYS=2 keeps one bit per set, larger caches keep an
// age matrix per set (row i bit j set => way i used more recently than way j).
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int unsigned WAYS = 2,
    parameter int unsigned SETS = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [idx_w(SETS)-1:0]   index,
    input  logic [way_w(WAYS)-1:0]   hit_way,
    input  logic                     update,
    input  logic [way_w(WAYS)-1:0]   fill_way,
    input  logic                     fill,
    output logic [way_w(WAYS)-1:0]   victim_way
);

    localparam int unsigned WW = way_w(WAYS);

    logic          touch;
    logic [WW-1:0] touch_way;

    assign touch     = update | fill;
    assign touch_way = fill ? fill_way : hit_way;

    if (WAYS == 1) begin : g_dm
        logic unused_lru;
        assign unused_lru = ^{clk, rst, index, touch, touch_way};
        assign victim_way = '0;
    end else if (WAYS == 2) begin : g_two
        // Bit points at the least-recently-used way of each set.
        logic [SETS-1:0] lru_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                lru_q <= '0;
            end else if (touch) begin
                lru_q[index] <= ~touch_way[0];
            end
        end

        assign victim_way = lru_q[index];
    end else begin : g_matrix
        logic [WAYS-1:0] age_q [SETS][WAYS];
        logic            found;

        // Touching way w marks it newer than every other way and clears
        // its column so no other way claims to be newer than it.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        age_q[s][w] <= '0;
                    end
                end
            end else if (touch) begin
                for (int j = 0; j < WAYS; j++) begin
                    if (WW'(j) != touch_way) begin
                        age_q[index][touch_way][j] <= 1'b1;
                        age_q[index][j][touch_way] <= 1'b0;
                    end
                end
            end
        end

        // The LRU way is the one newer than nobody (diagonal is never set).
        always_comb begin
            victim_way = '0;
            found      = 1'b0;
            for (int i = 0; i < WAYS; i++) begin
                if (!found && (age_q[index][i] == '0)) begin
                    victim_way = WW'(i);
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dcache_wb_setassoc.sv
// Write-back, write-allocate, N-way set-associative data cache for the MEM stage.
// Ports: clk, rst (sync, active-high); req_valid/req_we/req_addr/req_wdata/req_f3
// from EX/MEM; stall (combinational pipeline freeze); rdata/rdata_valid (registered
// load result); mem_req/mem_we/mem_addr/mem_wdata/mem_ready/mem_rvalid/mem_rdata
// line-granular valid/ready memory port.
// Optional build macro DCACHE_PERF_EN adds saturating perf_hits, perf_misses and
// perf_writebacks counters.
module dcache_wb_setassoc
    import dcache_pkg::*;
#(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [31:0]               req_wdata,
    input  logic [2:0]                req_f3,
    output logic                      stall,
    output logic [31:0]               rdata,
    output logic                      rdata_valid,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [32*LINE_WORDS-1:0]  mem_wdata,
    input  logic                      mem_ready,
    input  logic                      mem_rvalid,
    input  logic [32*LINE_WORDS-1:0]  mem_rdata
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]               perf_hits,
    output logic [31:0]               perf_misses,
    output logic [31:0]               perf_writebacks
`endif
);

    localparam int unsigned OW = off_w(LINE_WORDS);
    localparam int unsigned IW = idx_w(SETS);
    localparam int unsigned TW = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int unsigned WW = way_w(WAYS);
    localparam int unsigned LW = 32 * LINE_WORDS;
    localparam int unsigned LB = OW + 2;

    // Address fields of the held request.
    logic [OW-1:0] req_off;
    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [1:0]    bsel;

    assign bsel    = req_addr[1:0];
    assign req_off = req_addr[LB-1:2];
    assign req_idx = req_addr[LB+IW-1:LB];
    assign req_tag = req_addr[ADDR_W-1:ADDR_W-TW];

    // Storage: tags and data are not reset, valid/dirty are.
    logic [TW-1:0]   tag_q   [WAYS][SETS];
    logic [LW-1:0]   data_q  [WAYS][SETS];
    logic [SETS-1:0] valid_q [WAYS];
    logic [SETS-1:0] dirty_q [WAYS];

    state_e        state_q, state_d;
    logic [WW-1:0] victim_q, victim_d;
    logic          req_done_q, req_done_d;

    logic          hit;
    logic [WW-1:0] hit_way;
    logic [WW-1:0] lru_victim;
    logic [WW-1:0] pick_way;
    logic          pick_found;
    logic [LW-1:0] hit_line;
    logic [31:0]   hit_word;
    logic [3:0]    be;
    logic [31:0]   lanes;
    logic [31:0]   merged_word;
    logic [LW-1:0] merged_line;
    logic          idle;
    logic          acc_hit;
    logic          ld_hit;
    logic          st_wr;
    logic          miss;
    logic          fill_go;

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Victim: lowest-numbered invalid way, otherwise the LRU way.
    always_comb begin
        pick_way   = lru_victim;
        pick_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!pick_found && !valid_q[w][req_idx]) begin
                pick_way   = WW'(w);
                pick_found = 1'b1;
            end
        end
    end

    // Store merge into the hit line.
    assign hit_line = data_q[hit_way][req_idx];
    assign hit_word = hit_line[{req_off, 5'b00000} +: 32];
    assign be       = store_be(bsel, req_f3);
    assign lanes    = store_lanes(req_wdata, req_f3);

    always_comb begin
        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged_word[8*b +: 8] = lanes[8*b +: 8];
            end
        end
        merged_line = hit_line;
        merged_line[{req_off, 5'b00000} +: 32] = merged_word;
    end

    assign idle    = (state_q == S_IDLE);
    assign acc_hit = idle && req_valid && hit;
    assign ld_hit  = acc_hit && !req_we;
    assign st_wr   = acc_hit && req_we && (be != 4'b0000);
    assign miss    = idle && req_valid && !hit;
    // Fill data may arrive in the very cycle the request is accepted.
    assign fill_go = (state_q == S_REFILL) && mem_rvalid && (req_done_q || mem_ready);

    assign stall = !idle || (req_valid && !hit);

    dcache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk        (clk),
        .rst        (rst),
        .index      (req_idx),
        .hit_way    (hit_way),
        .update     (acc_hit),
        .fill_way   (victim_q),
        .fill       (fill_go),
        .victim_way (lru_victim)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            victim_q   <= '0;
            req_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            req_done_q <= req_done_d;
        end
    end

    // FSM next state and memory-port drive.
    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        req_done_d = req_done_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    victim_d   = pick_way;
                    req_done_d = 1'b0;
                    state_d    = (valid_q[pick_way][req_idx] && dirty_q[pick_way][req_idx])
                                 ? S_WB : S_REFILL;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[victim_q][req_idx], req_idx, {LB{1'b0}}};
                mem_wdata = data_q[victim_q][req_idx];
                if (mem_ready) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req  = !req_done_q;
                mem_addr = {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                if (fill_go) begin
                    state_d    = S_IDLE;
                    req_done_d = 1'b0;
                end else if (mem_ready) begin
                    req_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valid/dirty bits and registered load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= ld_hit;
            if (ld_hit) begin
                rdata <= load_fmt(hit_word, bsel, req_f3);
            end
            if (st_wr) begin
                dirty_q[hit_way][req_idx] <= 1'b1;
            end
            if (fill_go) begin
                valid_q[victim_q][req_idx] <= 1'b1;
                dirty_q[victim_q][req_idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays.
    always_ff @(posedge clk) begin
        if (st_wr) begin
            data_q[hit_way][req_idx] <= merged_line;
        end
        if (fill_go) begin
            data_q[victim_q][req_idx] <= mem_rdata;
            tag_q[victim_q][req_idx]  <= req_tag;
        end
    end

`ifdef DCACHE_PERF_EN
    // The hit that replays a just-filled request belongs to its miss.
    logic replay_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            replay_q        <= 1'b0;
            perf_hits       <= 32'd0;
            perf_misses     <= 32'd0;
            perf_writebacks <= 32'd0;
        end else begin
            if (fill_go) begin
                replay_q <= 1'b1;
            end else if (idle) begin
                replay_q <= 1'b0;
            end
            if (acc_hit && !replay_q && (perf_hits != '1)) begin
                perf_hits <= perf_hits + 32'd1;
            end
            if (miss && (perf_misses != '1)) begin
                perf_misses <= perf_misses + 32'd1;
            end
            if ((state_q == S_WB) && mem_ready && (perf_writebacks != '1)) begin
                perf_writebacks <= perf_writebacks + 32'd1;
            end
        end
    end
`endif

endmodule
